// File: rtl/rb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rb_pkg                                                      |
// | Brief   : Shared redundant-binary digit codes, op codes and encoder.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package rb_pkg;

    typedef struct packed {
        logic s1;
        logic s0;
    } rb_digit_t;

    localparam logic [1:0] RB_POS  = 2'b00;
    localparam logic [1:0] RB_ZERO = 2'b01;
    localparam logic [1:0] RB_NEG  = 2'b11;

    localparam logic [1:0] RB_OP_SUB  = 2'b00;
    localparam logic [1:0] RB_OP_A    = 2'b01;
    localparam logic [1:0] RB_OP_NEGB = 2'b10;
    localparam logic [1:0] RB_OP_RSVD = 2'b11;

    // d = a - b for one bit position; (1,0) is never emitted.
    function automatic rb_digit_t rb_encode(input logic a, input logic b);
        rb_digit_t d;
        case ({a, b})
            2'b10:   d = RB_POS;
            2'b01:   d = RB_NEG;
            default: d = RB_ZERO;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rb_digit_enc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rb_digit_enc                                                |
// | Brief   : One-digit (a_i, b_i) -> (s1, s0) signed-digit encoder.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rb_digit_enc
    import rb_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic s1_o,
    output logic s0_o
);

    rb_digit_t w_dig;

    assign w_dig = rb_encode(a_i, b_i);
    assign s1_o  = w_dig.s1;
    assign s0_o  = w_dig.s0;

endmodule
`default_nettype wire

// File: rtl/rb_operand_enc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rb_operand_enc                                              |
// | Brief   : Binary operand pair -> (S1,S0) signed-digit vectors, with   |
// |           a valid/ready output FIFO. RB_ENC_NZCOUNT_EN adds out_nz.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rb_operand_enc
    import rb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_s1,
    output logic [WIDTH:0]   out_s0,
    output logic             out_err
`ifdef RB_ENC_NZCOUNT_EN
    ,
    output logic [$clog2(WIDTH+2)-1:0] out_nz
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] w_ea;
    logic [WIDTH-1:0] w_eb;
    logic             w_err;
    logic [WIDTH-1:0] w_s1_lo;
    logic [WIDTH-1:0] w_s0_lo;
    logic [WIDTH:0]   w_s1;
    logic [WIDTH:0]   w_s0;
    logic             w_push;
    logic             w_pop;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [WIDTH:0] mem_s1_q  [DEPTH];
    logic [WIDTH:0] mem_s0_q  [DEPTH];
    logic           mem_err_q [DEPTH];

    always_comb begin
        w_ea = in_a;
        w_eb = in_b;
        case (in_op)
            RB_OP_A:    w_eb = '0;
            RB_OP_NEGB: w_ea = '0;
            default:    ;
        endcase
    end

    assign w_err = (in_op == RB_OP_RSVD);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_digit
            rb_digit_enc u_digit (
                .a_i  (w_ea[gi]),
                .b_i  (w_eb[gi]),
                .s1_o (w_s1_lo[gi]),
                .s0_o (w_s0_lo[gi])
            );
        end
    endgenerate

    // Top digit is a constant zero so sign extension is always absorbed.
    assign w_s1 = {1'b0, w_s1_lo};
    assign w_s0 = {1'b1, w_s0_lo};

`ifdef RB_ENC_NZCOUNT_EN
    localparam int NZW = $clog2(WIDTH + 2);

    logic [NZW-1:0] w_nz;
    logic [NZW-1:0] mem_nz_q [DEPTH];

    always_comb begin
        w_nz = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_nz = w_nz + NZW'(w_s1_lo[i] | ~w_s0_lo[i]);
        end
    end
`endif

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the empty-state outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_s1_q[k]  <= '0;
                mem_s0_q[k]  <= '0;
                mem_err_q[k] <= 1'b0;
`ifdef RB_ENC_NZCOUNT_EN
                mem_nz_q[k]  <= '0;
`endif
            end
        end else if (w_push) begin
            mem_s1_q[wr_ptr_q]  <= w_s1;
            mem_s0_q[wr_ptr_q]  <= w_s0;
            mem_err_q[wr_ptr_q] <= w_err;
`ifdef RB_ENC_NZCOUNT_EN
            mem_nz_q[wr_ptr_q]  <= w_nz;
`endif
        end
    end

    assign out_s1  = mem_s1_q[rd_ptr_q];
    assign out_s0  = mem_s0_q[rd_ptr_q];
    assign out_err = mem_err_q[rd_ptr_q];
`ifdef RB_ENC_NZCOUNT_EN
    assign out_nz  = mem_nz_q[rd_ptr_q];
`endif

endmodule
`default_nettype wire

// File: tb/tb_rb_operand_enc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_rb_operand_enc                                           |
// | Brief   : Scoreboard bench for rb_operand_enc (WIDTH=32, DEPTH=2).    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_rb_operand_enc;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int NZW   = $clog2(WIDTH + 2);

    typedef struct packed {
        logic [WIDTH:0]   s1;
        logic [WIDTH:0]   s0;
        logic             err;
        logic [NZW-1:0]   nz;
        logic [WIDTH:0]   diff;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_s1;
    logic [WIDTH:0]   out_s0;
    logic             out_err;
`ifdef RB_ENC_NZCOUNT_EN
    logic [NZW-1:0]   out_nz;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic hold_v = 1'b0;
    logic [WIDTH:0] hold_s1;
    logic [WIDTH:0] hold_s0;
    logic rnd_done;

    rb_operand_enc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s1    (out_s1),
        .out_s0    (out_s0),
        .out_err   (out_err)
`ifdef RB_ENC_NZCOUNT_EN
        ,
        .out_nz    (out_nz)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic digit values, mapped to (S1,S0) codes.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] op);
        exp_t e;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        int d;
        ea = (op == 2'b10) ? '0 : a;
        eb = (op == 2'b01) ? '0 : b;
        e.s1 = '0;
        e.s0 = '0;
        e.nz = '0;
        e.s0[WIDTH] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            d = int'(ea[i]) - int'(eb[i]);
            if (d == 1) begin
                e.s1[i] = 1'b0; e.s0[i] = 1'b0; e.nz = e.nz + 1'b1;
            end else if (d == -1) begin
                e.s1[i] = 1'b1; e.s0[i] = 1'b1; e.nz = e.nz + 1'b1;
            end else begin
                e.s1[i] = 1'b0; e.s0[i] = 1'b1;
            end
        end
        e.err  = (op == 2'b11);
        e.diff = {1'b0, ea} - {1'b0, eb};
        return e;
    endfunction

    // Converter view: sum of signed digits, modulo 2^(WIDTH+1).
    function automatic logic [WIDTH:0] conv(input logic [WIDTH:0] s1, input logic [WIDTH:0] s0);
        logic [WIDTH:0] acc;
        logic [WIDTH:0] one;
        acc = '0;
        one = 1;
        for (int i = 0; i <= WIDTH; i++) begin
            if (!s0[i])     acc = acc + (one << i);
            else if (s1[i]) acc = acc - (one << i);
        end
        return acc;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_s1", 64'(out_s1), 64'(hold_s1));
                chk("hold_s0", 64'(out_s0), 64'(hold_s0));
            end
            hold_v  = out_valid && !out_ready;
            hold_s1 = out_s1;
            hold_s0 = out_s0;
            if (out_valid) chk("invariant", 64'(out_s1 & ~out_s0), 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("s1", 64'(out_s1), 64'(e.s1));
                    chk("s0", 64'(out_s0), 64'(e.s0));
                    chk("err", 64'(out_err), 64'(e.err));
`ifdef RB_ENC_NZCOUNT_EN
                    chk("nz", 64'(out_nz), 64'(e.nz));
`endif
                    chk("conv", 64'(conv(out_s1, out_s0)), 64'(e.diff));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_op));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
        int  n;
        logic rdy;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = 2'b00;
        out_ready = 1'b0;
        rnd_done = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_s1", 64'(out_s1), 64'd0);
        chk("rst_s0", 64'(out_s0), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
`ifdef RB_ENC_NZCOUNT_EN
        chk("rst_nz", 64'(out_nz), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        out_ready = 1'b1;
        send(32'd5, 32'd3, 2'b00);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("sub_s1", 64'(out_s1), 64'h0_0000_0002);
        chk("sub_s0", 64'(out_s0), 64'h1_FFFF_FFFB);
        chk("sub_err", 64'(out_err), 64'd0);
`ifdef RB_ENC_NZCOUNT_EN
        chk("sub_nz", 64'(out_nz), 64'd2);
`endif
        send(32'hFFFF_FFFF, 32'h1234_5678, 2'b01);
        chk("opa_s1", 64'(out_s1), 64'd0);
        chk("opa_s0", 64'(out_s0), 64'h1_0000_0000);
`ifdef RB_ENC_NZCOUNT_EN
        chk("opa_nz", 64'(out_nz), 64'd32);
`endif
        send(32'hDEAD_BEEF, 32'd1, 2'b10);
        chk("negb_s1", 64'(out_s1), 64'h0_0000_0001);
        chk("negb_s0", 64'(out_s0), 64'h1_FFFF_FFFF);
        send(32'd5, 32'd3, 2'b11);
        chk("rsvd_s1", 64'(out_s1), 64'h0_0000_0002);
        chk("rsvd_s0", 64'(out_s0), 64'h1_FFFF_FFFB);
        chk("rsvd_err", 64'(out_err), 64'd1);
        @(posedge clk); #1;
        chk("drained_valid", 64'(out_valid), 64'd0);

        // Back-to-back with a draining sink: push and pop together.
        send(32'd10, 32'd20, 2'b00);
        send(32'd30, 32'd7, 2'b00);
        chk("pushpop_valid", 64'(out_valid), 64'd1);
        chk("pushpop_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Backpressure: two fill the FIFO, the third stalls.
        out_ready = 1'b0;
        send(32'h0000_00F0, 32'h0000_000F, 2'b00);
        send(32'h1, 32'h2, 2'b00);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_head_s1", 64'(out_s1), 64'h0_0000_000F);
        fork
            send(32'h3, 32'h3, 2'b01);
            begin
                repeat (3) begin
                    @(posedge clk); #2;
                    chk("stall_ready", 64'(in_ready), 64'd0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset with a full FIFO.
        out_ready = 1'b0;
        send(32'h11, 32'h22, 2'b00);
        send(32'h33, 32'h44, 2'b00);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_err", 64'(out_err), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'd7, 32'd2, 2'b00);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_s1", 64'(out_s1), 64'd0);
        chk("post_rst_s0", 64'(out_s0), 64'h1_FFFF_FFFA);
        @(posedge clk); #1;
        chk("post_rst_alone", 64'(out_valid), 64'd0);

        // Random traffic with random downstream readiness.
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    send($urandom, $urandom, 2'($urandom_range(0, 3)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #2;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("final_drain", 64'(out_valid), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
